// File: rtl/run_ctrl.sv
// Run sequencer: holds the core in reset, runs it, counts cycles,
// and reports done/timeout back to the host over a 4-phase req/done.
module run_ctrl #(
  parameter int RST_CYC = 2,
  parameter int TMO_CYC = 1000,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          core_done,
  output logic          core_rst,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycles
);

  localparam int RW = $clog2(RST_CYC + 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);
  localparam logic [CW-1:0] TMO_VAL  = CW'(TMO_CYC);

  // The counter must hold TMO_CYC without wrapping.
  generate
    if (RST_CYC < 1 || TMO_CYC < 1 ||
        ((64'(TMO_CYC) >> CW) != 64'd0)) begin : g_bad_param
      $error("run_ctrl: illegal RST_CYC/TMO_CYC/CW");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_RUN,
    S_FIN,
    S_TMO
  } state_t;

  state_t        st_q, st_d;
  logic [RW-1:0] rc_q, rc_d;
  logic [CW-1:0] cy_q, cy_d;

  // State, reset-hold counter and run-cycle counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q <= S_IDLE;
      rc_q <= '0;
      cy_q <= '0;
    end else begin
      st_q <= st_d;
      rc_q <= rc_d;
      cy_q <= cy_d;
    end
  end

  // Next state; in RUN an abort beats core_done, which beats timeout.
  always_comb begin
    st_d = st_q;
    rc_d = rc_q;
    cy_d = cy_q;
    unique case (st_q)
      S_IDLE: begin
        if (req) begin
          st_d = S_RST;
          rc_d = '0;
          cy_d = '0;
        end
      end
      S_RST: begin
        if (!req) begin
          st_d = S_IDLE;
        end else begin
          rc_d = rc_q + 1'b1;
          if (rc_q == RST_LAST) st_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!req) begin
          st_d = S_IDLE;
        end else if (core_done) begin
          st_d = S_FIN;
        end else if (cy_q == TMO_LAST) begin
          st_d = S_TMO;
          cy_d = TMO_VAL;
        end else begin
          cy_d = cy_q + 1'b1;
        end
      end
      S_FIN, S_TMO: begin
        if (!req) st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  // Moore output decode; core stays frozen everywhere except RUN.
  always_comb begin
    core_rst = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    timeout  = 1'b0;
    unique case (st_q)
      S_IDLE: ;
      S_RST:  busy = 1'b1;
      S_RUN: begin
        core_rst = 1'b0;
        busy     = 1'b1;
      end
      S_FIN:  done = 1'b1;
      S_TMO: begin
        done    = 1'b1;
        timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign cycles = cy_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Randomised bench for run_ctrl against a phase-level reference model.
// Short, hand-computed checks pin the model on the key scenarios.
module tb_run_ctrl;

  localparam int RST_CYC = 2;
  localparam int TMO_CYC = 10;
  localparam int CW      = 16;

  localparam int P_IDLE = 0;
  localparam int P_HOLD = 1;
  localparam int P_RUN  = 2;
  localparam int P_END  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req = 1'b0;
  logic          core_done = 1'b0;
  logic          core_rst;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycles;

  int n_vec = 0;
  int n_err = 0;

  int m_ph   = P_IDLE;
  int m_hold = 0;
  int m_cyc  = 0;
  bit m_to   = 1'b0;

  run_ctrl #(
    .RST_CYC(RST_CYC),
    .TMO_CYC(TMO_CYC),
    .CW     (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .core_done(core_done),
    .core_rst (core_rst),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout),
    .cycles   (cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(negedge reset) begin
    m_ph   = P_IDLE;
    m_hold = 0;
    m_cyc  = 0;
    m_to   = 1'b0;
  end

  // Advance the model on each edge, then check every output.
  always @(posedge clk) begin
    logic e_rst, e_busy, e_done, e_to;
    if (reset) begin
      case (m_ph)
        P_IDLE: if (req) begin
          m_ph = P_HOLD; m_hold = 0; m_cyc = 0;
        end
        P_HOLD: if (!req) m_ph = P_IDLE;
          else begin
            m_hold++;
            if (m_hold == RST_CYC) m_ph = P_RUN;
          end
        P_RUN: if (!req) m_ph = P_IDLE;
          else if (core_done) begin
            m_ph = P_END; m_to = 1'b0;
          end else begin
            m_cyc++;
            if (m_cyc == TMO_CYC) begin
              m_ph = P_END; m_to = 1'b1;
            end
          end
        default: if (!req) m_ph = P_IDLE;
      endcase
    end
    #1;
    e_rst  = (m_ph != P_RUN);
    e_busy = (m_ph == P_HOLD) || (m_ph == P_RUN);
    e_done = (m_ph == P_END);
    e_to   = e_done && m_to;
    n_vec++;
    if ({core_rst, busy, done, timeout, cycles} !==
        {e_rst, e_busy, e_done, e_to, CW'(m_cyc)}) begin
      n_err++;
      $display("FAIL cycle t=%0t got rst=%b busy=%b done=%b to=%b cyc=%0d want rst=%b busy=%b done=%b to=%b cyc=%0d",
               $time, core_rst, busy, done, timeout, cycles,
               e_rst, e_busy, e_done, e_to, m_cyc);
    end
  end

  // One run: raise req, drive core_done at RUN count done_at,
  // optionally drop req at RUN count abort_at.
  task automatic trial(input int done_at, input int abort_at,
                       input bit noise, output int rel_at);
    int k;
    rel_at = -1;
    @(negedge clk);
    req = 1'b1;
    core_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    for (k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (rel_at < 0 && !core_rst) rel_at = k;
      if (m_ph == P_END) break;
      if (abort_at >= 0 && m_ph == P_RUN && m_cyc == abort_at) begin
        req = 1'b0;
        core_done = 1'b0;
        break;
      end
      if (m_ph == P_RUN) core_done = (m_cyc == done_at);
      else core_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    if (k > 200) begin
      n_vec++;
      n_err++;
      $display("FAIL trial_bound: got %0d cycles want <=200", k);
    end
    core_done = 1'b0;
  endtask

  initial begin
    int lat;
    int d;
    int ab;
    repeat (3) @(negedge clk);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_cycles", cycles, 0);
    reset = 1'b1;
    @(negedge clk);

    trial(7, -1, 1'b1, lat);
    chk("norm_latency", lat, RST_CYC + 1);
    chk("norm_done", done, 1);
    chk("norm_timeout", timeout, 0);
    chk("norm_cycles", cycles, 7);
    chk("norm_freeze", core_rst, 1);
    repeat (3) @(negedge clk);
    chk("norm_hold", done, 1);
    req = 1'b0;
    @(negedge clk);
    chk("norm_drop_done", done, 0);
    chk("norm_drop_cyc", cycles, 7);

    trial(-1, -1, 1'b0, lat);
    chk("tmo_done", done, 1);
    chk("tmo_flag", timeout, 1);
    chk("tmo_cycles", cycles, TMO_CYC);
    req = 1'b0;
    @(negedge clk);
    chk("tmo_clr", {done, timeout}, 0);

    trial(TMO_CYC - 1, -1, 1'b0, lat);
    chk("sim_done", done, 1);
    chk("sim_timeout", timeout, 0);
    chk("sim_cycles", cycles, TMO_CYC - 1);
    req = 1'b0;
    @(negedge clk);

    trial(0, -1, 1'b0, lat);
    chk("first_cycles", cycles, 0);
    chk("first_done", done, 1);
    req = 1'b0;
    @(negedge clk);

    trial(-1, 5, 1'b0, lat);
    @(negedge clk);
    chk("abort_rst", core_rst, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_cycles", cycles, 5);
    req = 1'b1;
    @(negedge clk);
    chk("restart_cycles", cycles, 0);
    chk("restart_busy", busy, 1);

    repeat (4) @(negedge clk);
    chk("pre_ar_run", core_rst, 0);
    #2 reset = 1'b0;
    #1;
    chk("ar_core_rst", core_rst, 1);
    chk("ar_busy", busy, 0);
    chk("ar_cycles", cycles, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("ar_restart_busy", busy, 1);
    chk("ar_restart_rst", core_rst, 1);
    req = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 40; t++) begin
      d  = $urandom_range(0, TMO_CYC + 3);
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, TMO_CYC - 1) : -1;
      trial(d, ab, 1'b1, lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      req = 1'b0;
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk);
        core_done = 1'($urandom_range(0, 1));
      end
      core_done = 1'b0;
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
